// File: rtl/ysyx_220066_lsu.sv
// Load/store unit behind the M pipeline register.
// Runs one outstanding valid/ready access on the 64-bit data bus, aligns and
// extends load data, builds store strobes, and stalls M until completion.
module ysyx_220066_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        MemRd_in,
  input  logic        MemWr_in,
  input  logic [2:0]  MemOp_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  output logic        block_out,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic [63:0] rdata_out,
  output logic        done_out,
  output logic        err_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        cmd_rd, cmd_wr, cmd_err;
  logic [2:0]  cmd_op;
  logic [63:0] cmd_addr, cmd_wdata;
  logic        accept, op_err;
  logic [7:0]  mask_base;
  logic [63:0] rd_shift;

  // Sign/zero extension of the lane-shifted load word by funct3.
  function automatic logic [63:0] load_ext(input logic [2:0] op, input logic [63:0] sh);
    logic [63:0] res;
    res = '0;
    case (op)
      3'b000:  res = {{56{sh[7]}},  sh[7:0]};
      3'b001:  res = {{48{sh[15]}}, sh[15:0]};
      3'b010:  res = {{32{sh[31]}}, sh[31:0]};
      3'b011:  res = sh;
      3'b100:  res = {56'd0, sh[7:0]};
      3'b101:  res = {48'd0, sh[15:0]};
      3'b110:  res = {32'd0, sh[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  // Illegal-op and misalignment check on the live M-stage command.
  function automatic logic check_err(input logic rd, input logic wr,
                                     input logic [2:0] op, input logic [2:0] a);
    logic e;
    e = (rd & wr) | (rd & (op == 3'b111)) | (wr & op[2]);
    case (op[1:0])
      2'b01:   e = e | a[0];
      2'b10:   e = e | (a[1:0] != 2'b00);
      2'b11:   e = e | (a != 3'b000);
      default: ;
    endcase
    return e;
  endfunction

  assign accept = (state == IDLE) & valid_in & (MemRd_in | MemWr_in);
  assign op_err = check_err(MemRd_in, MemWr_in, MemOp_in, addr_in[2:0]);

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic for the single-outstanding bus handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_err ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_rsp_valid) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch; held stable for the whole transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cmd_rd    <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_op    <= 3'd0;
      cmd_addr  <= 64'd0;
      cmd_wdata <= 64'd0;
    end else if (accept) begin
      cmd_rd    <= MemRd_in;
      cmd_wr    <= MemWr_in;
      cmd_err   <= op_err;
      cmd_op    <= MemOp_in;
      cmd_addr  <= addr_in;
      cmd_wdata <= wdata_in;
    end
  end

  // Load result register; stores and errors complete with zero.
  always_ff @(posedge clk) begin
    if (!rst)
      rdata_out <= 64'd0;
    else if (state == WAIT && mem_rsp_valid)
      rdata_out <= cmd_rd ? load_ext(cmd_op, rd_shift) : 64'd0;
    else if (accept && op_err)
      rdata_out <= 64'd0;
  end

  // Store strobe pattern before lane shifting.
  always_comb begin
    mask_base = 8'h00;
    case (cmd_op[1:0])
      2'b00: mask_base = 8'h01;
      2'b01: mask_base = 8'h03;
      2'b10: mask_base = 8'h0F;
      2'b11: mask_base = 8'hFF;
      default: mask_base = 8'h00;
    endcase
  end

  assign rd_shift      = mem_rdata >> {cmd_addr[2:0], 3'b000};
  assign mem_addr      = {cmd_addr[63:3], 3'b000};
  assign mem_wdata     = cmd_wdata << {cmd_addr[2:0], 3'b000};
  assign mem_wmask     = cmd_wr ? (mask_base << cmd_addr[2:0]) : 8'h00;
  assign mem_wen       = cmd_wr;
  assign mem_req_valid = rst & (state == REQ);
  assign block_out     = rst & (accept | (state == REQ) | (state == WAIT));
  assign done_out      = rst & (state == DONE);
  assign err_out       = rst & (state == DONE) & cmd_err;

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Scoreboard bench for the load/store unit: bus requests and completions are
// predicted when each op is driven and matched as the DUT produces them.
module tb_ysyx_220066_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, MemRd_in, MemWr_in;
  logic [2:0]  MemOp_in;
  logic [63:0] addr_in, wdata_in;
  logic        block_out, mem_req_valid, mem_req_ready, mem_wen;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata, rdata_out;
  logic        done_out, err_out;

  ysyx_220066_lsu dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .MemRd_in(MemRd_in),
    .MemWr_in(MemWr_in), .MemOp_in(MemOp_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .block_out(block_out), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .rdata_out(rdata_out), .done_out(done_out),
    .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        wen;
  } bus_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input bit rd, input bit wr, input logic [2:0] op,
                                 input logic [63:0] a);
    int sz;
    if (rd && wr) return 1'b1;
    if (rd && op == 3'b111) return 1'b1;
    if (wr && op[2]) return 1'b1;
    sz = 1 << op[1:0];
    return (a % sz) != 0;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [2:0] op, input logic [63:0] a);
    logic [7:0] m;
    int lo, n;
    m = 8'h00;
    lo = int'(a[2:0]);
    n = 1 << op[1:0];
    for (int i = 0; i < 8; i++)
      if (i >= lo && i < lo + n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] exp_load(input logic [2:0] op, input logic [63:0] a,
                                           input logic [63:0] d);
    logic [63:0] sh;
    byte     b;
    shortint h;
    int      w;
    sh = d >> (8 * a[2:0]);
    b = sh[7:0];
    h = sh[15:0];
    w = sh[31:0];
    case (op)
      3'b000:  return longint'(b);
      3'b001:  return longint'(h);
      3'b010:  return longint'(w);
      3'b011:  return sh;
      3'b100:  return 64'(sh[7:0]);
      3'b101:  return 64'(sh[15:0]);
      3'b110:  return 64'(sh[31:0]);
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: check every visible request against the predicted one and every
  // completion against the predicted result.
  always @(negedge clk) begin
    if (mem_req_valid) begin
      if (bus_q.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        chk("req_addr", mem_addr, bus_q[0].addr);
        chk("req_wen",  64'(mem_wen), 64'(bus_q[0].wen));
        chk("req_mask", 64'(mem_wmask), 64'(bus_q[0].mask));
        if (bus_q[0].wen) chk("req_wdata", mem_wdata, bus_q[0].wdata);
        if (mem_req_ready) void'(bus_q.pop_front());
      end
    end
    if (done_out) begin
      if (res_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        chk("rdata", rdata_out, res_q[0].rdata);
        chk("err",   64'(err_out), 64'(res_q[0].err));
        void'(res_q.pop_front());
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    valid_in = 0; MemRd_in = 0; MemWr_in = 0;
    mem_req_ready = 0; mem_rsp_valid = 0;
  endtask

  // Present one command, play the bus with the given ready/response delays,
  // and return in the DONE cycle with the command still visible.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] rsp_data, input int rdy_wait, input int rsp_wait);
    res_t r;
    bus_t b;
    bit   er, hs, in_wait, got;
    int   rq, wt, cyc;
    er = exp_err(rd, wr, op, a);
    r.err = er;
    r.rdata = (er || !rd) ? 64'd0 : exp_load(op, a, rsp_data);
    res_q.push_back(r);
    if (!er) begin
      b.addr = a & ~64'h7;
      b.wdata = wd << (8 * a[2:0]);
      b.mask = wr ? exp_mask(op, a) : 8'h00;
      b.wen = wr;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    valid_in = 1; MemRd_in = rd; MemWr_in = wr; MemOp_in = op;
    addr_in = a; wdata_in = wd; mem_req_ready = 0; mem_rsp_valid = 0;
    #1 chk("blk_accept", 64'(block_out), 1);
    hs = 0; in_wait = 0; got = 0; rq = 0; wt = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      mem_req_ready = 0; mem_rsp_valid = 0;
      if (hs) begin in_wait = 1; hs = 0; end
      if (done_out) begin got = 1; break; end
      chk("blk_busy", 64'(block_out), 1);
      if (mem_req_valid) begin
        if (rq >= rdy_wait) begin mem_req_ready = 1; hs = 1; end
        rq++;
      end else if (in_wait) begin
        if (wt >= rsp_wait) begin mem_rsp_valid = 1; mem_rdata = rsp_data; end
        wt++;
      end
    end
    if (!got) chk("timeout", 0, 1);
    else begin
      chk("latency", 64'(cyc), 64'(er ? 1 : 3 + rdy_wait + rsp_wait));
      chk("blk_done", 64'(block_out), 0);
    end
  endtask

  initial begin
    bus_t b;
    rst = 0; valid_in = 1; MemRd_in = 1; MemWr_in = 0; MemOp_in = 3'b011;
    addr_in = 64'h8000_0000; wdata_in = 0; mem_req_ready = 1;
    mem_rsp_valid = 0; mem_rdata = 0;

    // Reset state with a live command present
    repeat (2) @(posedge clk);
    #1;
    chk("rst_block", 64'(block_out), 0);
    chk("rst_reqv",  64'(mem_req_valid), 0);
    chk("rst_done",  64'(done_out), 0);
    chk("rst_err",   64'(err_out), 0);
    chk("rst_rdata", rdata_out, 0);
    rst = 1; valid_in = 0; MemRd_in = 0; mem_req_ready = 0;

    // Directed cases
    do_op(1, 0, 3'b000, 64'h8000_0003, 0, 64'h1122_3344_8566_7788, 0, 0);
    idle();
    do_op(1, 0, 3'b100, 64'h8000_0003, 0, 64'h1122_3344_8566_7788, 0, 0);
    idle();
    do_op(0, 1, 3'b001, 64'h8000_0006, 64'hABCD, 0, 0, 0);
    idle();
    do_op(1, 0, 3'b010, 64'h8000_0002, 0, 64'hDEAD_BEEF_0000_1111, 0, 0);
    idle();
    do_op(1, 0, 3'b011, 64'h8000_0010, 0, 64'h0123_4567_89AB_CDEF, 3, 0);
    idle();
    do_op(1, 0, 3'b010, 64'h8000_0024, 0, 64'h8765_4321_0F0F_F0F0, 0, 1);
    do_op(0, 1, 3'b011, 64'h8000_0028, 64'hCAFE_F00D_1234_5678, 0, 0, 2);
    idle();
    do_op(1, 0, 3'b111, 64'h8000_0000, 0, 0, 0, 0);
    do_op(0, 1, 3'b100, 64'h8000_0000, 64'h55, 0, 0, 0);
    do_op(1, 1, 3'b000, 64'h8000_0001, 64'h55, 0, 0, 0);
    idle();
    do_op(1, 0, 3'b001, 64'h8000_0002, 0, 64'h0000_0000_F00D_0000, 1, 1);
    do_op(1, 0, 3'b110, 64'h8000_0004, 0, 64'h9ABC_DEF0_0000_0000, 0, 0);
    idle();

    // Reset during WAIT, then a stale response
    b.addr = 64'h8000_1000; b.wdata = 0; b.mask = 8'h00; b.wen = 1'b0;
    bus_q.push_back(b);
    @(posedge clk); #1;
    valid_in = 1; MemRd_in = 1; MemWr_in = 0; MemOp_in = 3'b011; addr_in = 64'h8000_1000;
    @(posedge clk); #1;
    chk("rmid_reqv", 64'(mem_req_valid), 1);
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0; rst = 0;
    #1;
    chk("rmid_block", 64'(block_out), 0);
    chk("rmid_done",  64'(done_out), 0);
    @(posedge clk); #1;
    rst = 1; valid_in = 0; MemRd_in = 0;
    mem_rsp_valid = 1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    #1;
    chk("rmid_rdata", rdata_out, 0);
    chk("rmid_reqv2", 64'(mem_req_valid), 0);
    chk("rmid_blk2",  64'(block_out), 0);
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    chk("rmid_stale", 64'(done_out), 0);
    do_op(1, 0, 3'b000, 64'h8000_2007, 0, 64'h7F00_0000_0000_0000, 0, 0);
    idle();

    // Randomised ops
    for (int i = 0; i < 12; i++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = !rd || ($urandom_range(0, 7) == 0);
      do_op(rd, wr, 3'($urandom_range(0, 7)), {32'h8000_0000, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("res_left", 64'(res_q.size()), 0);
    chk("bus_left", 64'(bus_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_lsu.md
# ysyx_220066_lsu

Load/store unit directly downstream of the M pipeline register. It consumes the registered memory command the M stage holds (read/write, MemOp, address, store data) and runs a single-outstanding valid/ready transaction on the 64-bit data-memory bus. It aligns and extends load data, builds store byte masks, and holds the pipeline via `block_out` until the access completes.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-low
- `valid_in`  in  1  M-stage slot holds a valid instruction
- `MemRd_in`  in  1  load request
- `MemWr_in`  in  1  store request
- `MemOp_in`  in  3  RISC-V funct3 size/sign code
- `addr_in`  in  64  byte address
- `wdata_in`  in  64  store data, right-justified
- `block_out`  out  1  stall to M stage; M must not advance while high
- `mem_req_valid`  out  1  bus request valid
- `mem_req_ready`  in  1  bus accepts request
- `mem_wen`  out  1  request is a write
- `mem_addr`  out  64  `{addr[63:3],3'b000}`
- `mem_wdata`  out  64  lane-shifted store data
- `mem_wmask`  out  8  byte strobes; 0 for reads
- `mem_rsp_valid`  in  1  bus response / write ack
- `mem_rdata`  in  64  aligned 8-byte read data
- `rdata_out`  out  64  extended load result
- `done_out`  out  1  one-cycle completion pulse
- `err_out`  out  1  qualifies `done_out`: misaligned or illegal op

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **Accept:** in IDLE with `valid_in & (MemRd_in | MemWr_in)`, latch all command fields.
- **Error check (at accept):** the access is an error, with no bus access, if any of the following holds:
  - both `MemRd_in` and `MemWr_in` are set;
  - load with MemOp=111;
  - store with MemOp[2]=1;
  - misaligned: half with a[0]≠0, word with a[1:0]≠0, dword with a[2:0]≠0.
- **Transitions:**
  - IDLE→REQ on an accepted legal op.
  - IDLE→DONE on an error.
  - REQ→WAIT when `mem_req_valid & mem_req_ready`.
  - WAIT→DONE on `mem_rsp_valid`.
  - DONE→IDLE unconditionally.
- **Store path:**
  - `mem_wdata = wdata << (8*a[2:0])`.
  - `mem_wmask` = {01,03,0F,FF}[MemOp[1:0]] << a[2:0].
- **Load path:**
  - `sh = mem_rdata >> (8*a[2:0])`.
  - MemOp 000/001/010 sign-extend 8/16/32 bits of `sh`.
  - 011 passes `sh` through.
  - 100/101/110 zero-extend 8/16/32 bits.
  - The result is registered into `rdata_out` on the WAIT→DONE edge.
  - Stores leave `rdata_out` = 0.
- **Bus signal hold:** `mem_req_valid` = (state==REQ). Address, data, mask and wen are driven from the latched command and stay stable while REQ and ready=0.
- **Responses:** any `mem_rsp_valid` outside WAIT is ignored.

## Timing
- `block_out` = (IDLE & accept condition) | REQ | WAIT. This is combinational, so M holds through the accept cycle. `block_out` is low in DONE, so M advances on the DONE edge.
- DONE never re-accepts, even though the old op is still visible on the inputs that cycle.
- Minimum legal access is 4 cycles: accept (c0), REQ with ready (c1), WAIT with rsp (c2), DONE (c3). Each cycle of ready=0 or late rsp adds 1.
- Error access takes 2 cycles: accept (c0), DONE with `err_out`=1 (c1).
- `done_out` and `err_out` are high only in DONE. `rdata_out` is valid in DONE and held until the next completion.
- Same-cycle ready and rsp in REQ do not complete the access; rsp must arrive in WAIT.
- **Reset (rst=0 at an edge):** state=IDLE, latched command=0, `rdata_out`=0. While rst=0, `done_out`, `err_out`, `mem_req_valid` and `block_out` are forced 0.
- **Reset mid-REQ/WAIT:** abandon the transaction; a later stale response is dropped.

## Test plan
- **LB/LBU:** LB at addr 0x8000_0003 with rdata 0x1122_3344_8566_7788 -> `rdata_out` 0xFFFF_FFFF_FFFF_FF85 in c3. LBU with the same stimulus -> 0x85.
- **SH:** SH at 0x8000_0006, wdata 0xABCD -> `mem_addr` 0x8000_0000, `mem_wdata` 0xABCD_0000_0000_0000, `mem_wmask` 0xC0, `mem_wen`=1. `done_out` at rsp+1 with `rdata_out` 0.
- **Misaligned LW:** LW at 0x8000_0002 -> `mem_req_valid` never high, `block_out` high c0 only, `done_out`=`err_out`=1 in c1.
- **Backpressure:** LD with `mem_req_ready` low 3 cycles -> request fields stable 4 cycles, `block_out` high throughout, `done_out` in c6.
- **Back-to-back:** LW then SD presented consecutively -> exactly one bus request per op, with no re-accept in the first DONE. MemOp=111 load -> err.
- **Reset mid-op:** rst=0 for one edge during WAIT, then rsp arrives -> state IDLE, no `done_out`, outputs 0, next op proceeds normally.
